mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 31 +++
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the cache requesters, the memory arbiter and the memory.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_arbiter_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ-1:0]        wr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic                      mem_en;
    logic                      mem_wr;
    logic [DATA_W-1:0]         mem_rdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        done;
    logic [DATA_W-1:0]         rdata;
    logic                      busy;

    modport slave (
        input  req, addr, wr, wdata, mem_rdata,
        output mem_addr, mem_wdata, mem_en, mem_wr, gnt, done, rdata, busy
    );

    modport master (
        output req, addr, wr, wdata, mem_rdata,
        input  mem_addr, mem_wdata, mem_en, mem_wr, gnt, done, rdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for NUM_REQ caches. One access at a time:
// IDLE (arbitrate) -> BUSY (MEM_LAT cycles of mem_en) -> RESP (one-cycle done).
// Define MEM_ARB_ROUND_ROBIN_EN for rotating priority; otherwise index 0 wins.
module mem_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned MEM_LAT = 4
) (
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.slave bus
);
    localparam int unsigned CntW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                wr_q, wr_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                any_req;
    logic [NUM_REQ-1:0]  win_oh;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_wr;

    assign any_req = |bus.req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam int unsigned PtrW = $clog2(NUM_REQ);

    logic [PtrW-1:0] ptr_q, ptr_d, ptr_nxt;

    // Rotating priority: first requester at or above the pointer, else wrap to the lowest.
    always_comb begin
        win_oh  = '0;
        ptr_nxt = ptr_q;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if ((win_oh == '0) && bus.req[i] && (i >= int'(ptr_q))) begin
                win_oh[i] = 1'b1;
                ptr_nxt   = (i == int'(NUM_REQ) - 1) ? '0 : PtrW'(i + 1);
            end
        end
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if ((win_oh == '0) && bus.req[i]) begin
                win_oh[i] = 1'b1;
                ptr_nxt   = (i == int'(NUM_REQ) - 1) ? '0 : PtrW'(i + 1);
            end
        end
    end

    // Pointer advances only when a grant is actually issued.
    always_comb begin
        ptr_d = ptr_q;
        if ((state_q == StIdle) && any_req) begin
            ptr_d = ptr_nxt;
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority: isolate the lowest set request bit.
    always_comb begin
        win_oh = bus.req & (~bus.req + NUM_REQ'(1));
    end
`endif

    // One-hot mux of the winner's request fields.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wr    = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (win_oh[i]) begin
                sel_addr  = bus.addr[i*ADDR_W +: ADDR_W];
                sel_wdata = bus.wdata[i*DATA_W +: DATA_W];
                sel_wr    = bus.wr[i];
            end
        end
    end

    // Next-state logic: arbitration only in IDLE, latched request held through BUSY.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        gnt_d   = gnt_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d = StBusy;
                    cnt_d   = CntW'(MEM_LAT - 1);
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    wr_d    = sel_wr;
                    gnt_d   = win_oh;
                end
            end
            StBusy: begin
                if (cnt_q == '0) begin
                    state_d = StResp;
                    rdata_d = wr_q ? '0 : bus.mem_rdata;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
                addr_d  = '0;
                wdata_d = '0;
                wr_d    = 1'b0;
                gnt_d   = '0;
                rdata_d = '0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and latched-request registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            gnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            gnt_q   <= gnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Outputs decoded from registered state only, so reset clears them at once.
    assign bus.mem_en    = (state_q == StBusy);
    assign bus.mem_addr  = (state_q == StBusy) ? addr_q : '0;
    assign bus.mem_wdata = (state_q == StBusy) ? wdata_q : '0;
    assign bus.mem_wr    = (state_q == StBusy) ? wr_q : 1'b0;
    assign bus.gnt       = gnt_q;
    assign bus.done      = (state_q == StResp) ? gnt_q : '0;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (NUM_REQ=2, MEM_LAT=4): directed vector table,
// hand-written corner sequences, then constrained-random traffic against a
// transaction-level reference model. Honours MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;
    localparam int NREQ = 2;
    localparam int LAT  = 4;

    logic        clk;
    logic        rst_n;
    logic        use_mem;
    logic [15:0] rdata_drv;
    int          checks;
    int          errors;
    int          cyc;

    mem_arbiter_if #(.NUM_REQ(NREQ), .ADDR_W(16), .DATA_W(16)) ifc ();

    mem_arbiter #(
        .NUM_REQ(NREQ),
        .ADDR_W (16),
        .DATA_W (16),
        .MEM_LAT(LAT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifc)
    );

    // Memory contents as a fixed function of the address.
    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A5A;
    endfunction

    assign ifc.mem_rdata = use_mem ? mem_fn(ifc.mem_addr) : rdata_drv;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: transaction-level, tracks cycles elapsed since the grant.
    int          phase;
    int          m_ptr;
    logic [1:0]  m_oh;
    logic [15:0] m_addr;
    logic [15:0] m_wdata;
    logic        m_wr;
    logic [15:0] m_rdata;

    function automatic int pick(input logic [1:0] r);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        for (int off = 0; off < NREQ; off++) begin
            if (r[(m_ptr + off) % NREQ]) return (m_ptr + off) % NREQ;
        end
        return 0;
`else
        for (int i = 0; i < NREQ; i++) begin
            if (r[i]) return i;
        end
        return 0;
`endif
    endfunction

    task automatic model_edge();
        int w;
        if (!rst_n) begin
            phase = 0;
            m_ptr = 0;
            m_oh  = '0;
        end else if (phase == 0) begin
            if (ifc.req != 2'b00) begin
                w       = pick(ifc.req);
                m_oh    = 2'(1 << w);
                m_addr  = ifc.addr[w*16 +: 16];
                m_wdata = ifc.wdata[w*16 +: 16];
                m_wr    = ifc.wr[w];
                m_ptr   = (w + 1) % NREQ;
                phase   = 1;
            end
        end else if (phase == LAT) begin
            m_rdata = m_wr ? 16'h0 : (use_mem ? mem_fn(m_addr) : rdata_drv);
            phase   = LAT + 1;
        end else if (phase == LAT + 1) begin
            phase = 0;
        end else begin
            phase = phase + 1;
        end
    endtask

    // {pad, busy, gnt, done, mem_en, mem_wr, mem_addr, mem_wdata, rdata}
    function automatic logic [63:0] act_vec();
        return {9'b0, ifc.busy, ifc.gnt, ifc.done, ifc.mem_en, ifc.mem_wr,
                ifc.mem_addr, ifc.mem_wdata, ifc.rdata};
    endfunction

    function automatic logic [63:0] exp_vec();
        if (phase == 0) return 64'h0;
        if (phase <= LAT) return {9'b0, 1'b1, m_oh, 2'b00, 1'b1, m_wr, m_addr, m_wdata, 16'h0};
        return {9'b0, 1'b1, m_oh, m_oh, 1'b0, 1'b0, 16'h0, 16'h0, m_rdata};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check("model", act_vec(), exp_vec());
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [15:0] rdata;
        logic [1:0]  e_gnt;
        logic        e_wr;
        logic [15:0] e_addr;
        logic [15:0] e_wdata;
        logic [15:0] e_rdata;
    } vec_t;

    vec_t        tbl[4];
    int          gcyc[$];
    logic [1:0]  gval[$];
    logic [1:0]  exp_seq[3];
    logic [1:0]  prev;
    logic [1:0]  pend;
    int          seen;

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        phase     = 0;
        m_ptr     = 0;
        m_oh      = '0;
        m_addr    = '0;
        m_wdata   = '0;
        m_wr      = 1'b0;
        m_rdata   = '0;
        use_mem   = 1'b0;
        rdata_drv = 16'h0;
        ifc.req   = '0;
        ifc.wr    = '0;
        ifc.addr  = '0;
        ifc.wdata = '0;
        rst_n     = 1'b1;

        // req, wr, addr{1,0}, wdata{1,0}, mem_rdata, exp gnt, wr, addr, wdata, rdata
        tbl[0] = '{2'b01, 2'b00, 32'h0000_1234, 32'h0000_0000, 16'hBEEF,
                   2'b01, 1'b0, 16'h1234, 16'h0000, 16'hBEEF};
        tbl[1] = '{2'b10, 2'b10, 32'h0040_0000, 32'h00AA_0000, 16'h1111,
                   2'b10, 1'b1, 16'h0040, 16'h00AA, 16'h0000};
        tbl[2] = '{2'b11, 2'b00, 32'h3333_2222, 32'h0000_0000, 16'h5555,
                   2'b01, 1'b0, 16'h2222, 16'h0000, 16'h5555};
`ifdef MEM_ARB_ROUND_ROBIN_EN
        tbl[3] = '{2'b11, 2'b11, 32'hB000_A000, 32'h0202_0101, 16'h7777,
                   2'b10, 1'b1, 16'hB000, 16'h0202, 16'h0000};
        exp_seq = '{2'b01, 2'b10, 2'b01};
`else
        tbl[3] = '{2'b11, 2'b11, 32'hB000_A000, 32'h0202_0101, 16'h7777,
                   2'b01, 1'b1, 16'hA000, 16'h0101, 16'h0000};
        exp_seq = '{2'b01, 2'b01, 2'b01};
`endif

        // Reset state.
        #1 rst_n = 1'b0;
        #1 check("reset_outputs", act_vec(), 64'h0);
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();

        // Directed vectors: latency and held values.
        for (int v = 0; v < 4; v++) begin
            ifc.req   = tbl[v].req;
            ifc.wr    = tbl[v].wr;
            ifc.addr  = tbl[v].addr;
            ifc.wdata = tbl[v].wdata;
            rdata_drv = tbl[v].rdata;
            tick();
            for (int c = 0; c < LAT; c++) begin
                check($sformatf("vec%0d_busy%0d", v, c),
                      {20'h0, ifc.gnt, ifc.mem_en, ifc.mem_wr, ifc.mem_addr, ifc.mem_wdata,
                       ifc.done, ifc.rdata},
                      {20'h0, tbl[v].e_gnt, 1'b1, tbl[v].e_wr, tbl[v].e_addr, tbl[v].e_wdata,
                       2'b00, 16'h0});
                tick();
            end
            check($sformatf("vec%0d_resp", v),
                  {43'h0, ifc.gnt, ifc.done, ifc.mem_en, ifc.rdata},
                  {43'h0, tbl[v].e_gnt, tbl[v].e_gnt, 1'b0, tbl[v].e_rdata});
            ifc.req = '0;
            tick();
            check($sformatf("vec%0d_idle", v), act_vec(), 64'h0);
        end

        // Contention with requests held: grant order and 6-cycle period.
        ifc.req   = 2'b11;
        ifc.wr    = 2'b00;
        ifc.addr  = 32'hD000_C000;
        rdata_drv = 16'h0F0F;
        prev      = '0;
        for (int c = 0; c < 40 && gval.size() < 3; c++) begin
            tick();
            if (ifc.gnt != 2'b00 && prev == 2'b00) begin
                gcyc.push_back(c);
                gval.push_back(ifc.gnt);
            end
            prev = ifc.gnt;
        end
        check("contention_count", 64'(gval.size()), 64'd3);
        if (gval.size() == 3) begin
            for (int g = 0; g < 3; g++) check($sformatf("contention_gnt%0d", g),
                                              64'(gval[g]), 64'(exp_seq[g]));
            check("contention_gap0", 64'(gcyc[1] - gcyc[0]), 64'(LAT + 2));
            check("contention_gap1", 64'(gcyc[2] - gcyc[1]), 64'(LAT + 2));
        end
        ifc.req = '0;
        for (int c = 0; c < 10 && ifc.busy; c++) tick();
        check("contention_drain", 64'(ifc.busy), 64'd0);
        tick();

        // Winner drops req and the other requester changes addr mid-access.
        ifc.req   = 2'b01;
        ifc.addr  = 32'h1111_0F0F;
        rdata_drv = 16'h4242;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        // Move the pointer back to 0 so requester 0 wins regardless of history.
        if (m_ptr != 0) begin
            ifc.req = 2'b10;
            tick();
            ifc.req = '0;
            for (int c = 0; c < 10 && ifc.busy; c++) tick();
            ifc.req = 2'b01;
        end
`endif
        tick();
        check("midchg_addr_c1", 64'(ifc.mem_addr), 64'h0F0F);
        ifc.req  = 2'b10;
        ifc.addr = 32'h7777_0F0F;
        for (int c = 2; c <= LAT; c++) begin
            tick();
            check($sformatf("midchg_addr_c%0d", c), {47'h0, ifc.mem_en, ifc.mem_addr},
                  {47'h0, 1'b1, 16'h0F0F});
        end
        tick();
        check("midchg_done", {46'h0, ifc.done, ifc.rdata}, {46'h0, 2'b01, 16'h4242});
        ifc.req = '0;
        tick();
        tick();

        // Reset in the second BUSY cycle: outputs clear at once, no done, pointer cleared.
        ifc.req  = 2'b01;
        ifc.addr = 32'h0000_1357;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1 check("midreset_outputs", act_vec(), 64'h0);
        ifc.req = 2'b11;
        tick();
        tick();
        check("midreset_held", act_vec(), 64'h0);
        #2 rst_n = 1'b1;
        tick();
        check("midreset_regrant", 64'(ifc.gnt), 64'h1);
        seen = 0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            tick();
            if (ifc.done != 2'b00) seen = 1;
        end
        check("midreset_done", 64'(seen), 64'd1);
        ifc.req = '0;
        tick();
        tick();

        // Random traffic: each requester holds req until its done is observed.
        use_mem = 1'b1;
        pend    = '0;
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i]) begin
                    ifc.addr[i*16 +: 16] = 16'($urandom);
                    if ($urandom_range(2) == 0) begin
                        pend[i]               = 1'b1;
                        ifc.req[i]            = 1'b1;
                        ifc.wr[i]             = 1'($urandom_range(1));
                        ifc.wdata[i*16 +: 16] = 16'($urandom);
                    end
                end
            end
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (ifc.done[i]) begin
                    pend[i]    = 1'b0;
                    ifc.req[i] = 1'b0;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
